// File: rtl/mem_test_ctrl_if.sv
// Signal bundle between the pin-side command source / memory array and the
// memory test controller. The controller uses the slave view.
interface mem_test_ctrl_if #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 8
);
  logic                 cmd_valid;
  logic [7:0]           cmd_byte;
  logic                 cmd_ready;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic                 bist_done;
  logic                 bist_fail;
  logic [7:0]           fail_cnt;
  logic [ADDR_BITS-1:0] first_fail_addr;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic                 mem_we;
  logic                 mem_re;
  logic [DATA_BITS-1:0] mem_rdata;

  modport master (
    output cmd_valid, cmd_byte, mem_rdata,
    input  cmd_ready, rd_data, rd_valid, bist_done, bist_fail, fail_cnt,
           first_fail_addr, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    input  cmd_valid, cmd_byte, mem_rdata,
    output cmd_ready, rd_data, rd_valid, bist_done, bist_fail, fail_cnt,
           first_fail_addr, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/mem_test_ctrl.sv
// Byte-command sequencer and BIST engine driving the write/read port of an
// on-chip memory array; all outputs are registered.
module mem_test_ctrl #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_test_ctrl_if.slave bus
);
  localparam int CNT_BITS = ADDR_BITS + 1;
  localparam logic [CNT_BITS-1:0]  N_WORDS   = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [CNT_BITS-1:0]  CNT_ZERO  = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0]  CNT_ONE   = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] ADDR_ZERO = {ADDR_BITS{1'b0}};
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = {ADDR_BITS{1'b1}};
  localparam logic [DATA_BITS-1:0] DATA_ZERO = {DATA_BITS{1'b0}};

  localparam logic [1:0] OP_SET_ADDR = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_READ     = 2'b10;
  localparam logic [1:0] OP_BIST     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_WR     = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_RD_CAP = 3'd4,
    ST_FILL   = 3'd5,
    ST_CHECK  = 3'd6
  } state_t;

  function automatic logic [DATA_BITS-1:0] bist_pattern(input logic [1:0]           sel,
                                                        input logic [ADDR_BITS-1:0] a);
    logic [DATA_BITS-1:0] p;
    case (sel)
      2'd0:    p = {DATA_BITS{1'b0}};
      2'd1:    p = {DATA_BITS{1'b1}};
      2'd2:    p = a[0] ? {(DATA_BITS/2){2'b10}} : {(DATA_BITS/2){2'b01}};
      2'd3:    p = DATA_BITS'(a);
      default: p = {DATA_BITS{1'b0}};
    endcase
    return p;
  endfunction

  state_t               state_r, state_nxt_s;
  logic [ADDR_BITS-1:0] addr_r, addr_nxt_s;
  logic                 inc_r, inc_nxt_s;
  logic [1:0]           pat_r, pat_nxt_s;
  logic [CNT_BITS-1:0]  chk_cnt_r, chk_cnt_nxt_s;
  logic                 bist_start_s;

  logic                 cmd_ready_r;
  logic [DATA_BITS-1:0] rd_data_r;
  logic                 rd_valid_r;
  logic                 bist_done_r;
  logic                 bist_fail_r;
  logic [7:0]           fail_cnt_r;
  logic [ADDR_BITS-1:0] first_fail_addr_r;
  logic [ADDR_BITS-1:0] mem_addr_r, mem_addr_nxt_s;
  logic [DATA_BITS-1:0] mem_wdata_r, mem_wdata_nxt_s;
  logic                 mem_we_r, mem_we_nxt_s;
  logic                 mem_re_r, mem_re_nxt_s;

  logic                 cmd_accept_s;
  logic [1:0]           opcode_s;
  logic                 cmp_en_s;
  logic [ADDR_BITS-1:0] cmp_addr_s;
  logic                 miscmp_s;
  logic                 unused_cmd_bits_s;

  assign cmd_accept_s      = bus.cmd_valid & cmd_ready_r;
  assign opcode_s          = bus.cmd_byte[7:6];
  assign unused_cmd_bits_s = ^bus.cmd_byte;

  // Next-state, address bookkeeping and next-cycle array-port decode
  always_comb begin
    state_nxt_s     = state_r;
    addr_nxt_s      = addr_r;
    inc_nxt_s       = inc_r;
    pat_nxt_s       = pat_r;
    chk_cnt_nxt_s   = chk_cnt_r;
    bist_start_s    = 1'b0;
    mem_we_nxt_s    = 1'b0;
    mem_re_nxt_s    = 1'b0;
    mem_addr_nxt_s  = ADDR_ZERO;
    mem_wdata_nxt_s = DATA_ZERO;

    case (state_r)
      ST_IDLE: begin
        if (cmd_accept_s) begin
          case (opcode_s)
            OP_SET_ADDR: addr_nxt_s = bus.cmd_byte[ADDR_BITS-1:0];
            OP_WRITE: begin
              inc_nxt_s   = bus.cmd_byte[0];
              state_nxt_s = ST_WDATA;
            end
            OP_READ: begin
              inc_nxt_s   = bus.cmd_byte[0];
              state_nxt_s = ST_RD_REQ;
            end
            OP_BIST: begin
              pat_nxt_s     = bus.cmd_byte[1:0];
              addr_nxt_s    = ADDR_ZERO;
              chk_cnt_nxt_s = CNT_ZERO;
              bist_start_s  = 1'b1;
              state_nxt_s   = ST_FILL;
            end
            default: state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (cmd_accept_s) begin
          mem_wdata_nxt_s = bus.cmd_byte[DATA_BITS-1:0];
          state_nxt_s     = ST_WR;
        end else begin
          state_nxt_s = ST_WDATA;
        end
      end
      ST_WR: begin
        addr_nxt_s  = addr_r + {{(ADDR_BITS-1){1'b0}}, inc_r};
        state_nxt_s = ST_IDLE;
      end
      ST_RD_REQ: state_nxt_s = ST_RD_CAP;
      ST_RD_CAP: begin
        addr_nxt_s  = addr_r + {{(ADDR_BITS-1){1'b0}}, inc_r};
        state_nxt_s = ST_IDLE;
      end
      ST_FILL: begin
        // addr walks 0..N-1 and wraps back to 0, ready for the post-BIST state
        addr_nxt_s = addr_r + ADDR_ONE;
        if (addr_r == ADDR_LAST) begin
          state_nxt_s = ST_CHECK;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_CHECK: begin
        if (chk_cnt_r == N_WORDS) begin
          state_nxt_s = ST_IDLE;
        end else begin
          chk_cnt_nxt_s = chk_cnt_r + CNT_ONE;
          state_nxt_s   = ST_CHECK;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    case (state_nxt_s)
      ST_WR: begin
        mem_we_nxt_s   = 1'b1;
        mem_addr_nxt_s = addr_nxt_s;
      end
      ST_RD_REQ: begin
        mem_re_nxt_s   = 1'b1;
        mem_addr_nxt_s = addr_nxt_s;
      end
      ST_FILL: begin
        mem_we_nxt_s    = 1'b1;
        mem_addr_nxt_s  = addr_nxt_s;
        mem_wdata_nxt_s = bist_pattern(pat_nxt_s, addr_nxt_s);
      end
      ST_CHECK: begin
        // the final CHECK cycle only compares; no read is issued
        if (chk_cnt_nxt_s != N_WORDS) begin
          mem_re_nxt_s   = 1'b1;
          mem_addr_nxt_s = chk_cnt_nxt_s[ADDR_BITS-1:0];
        end else begin
          mem_re_nxt_s = 1'b0;
        end
      end
      default: mem_re_nxt_s = 1'b0;
    endcase
  end

  // Compare the word read in the previous CHECK cycle against its pattern
  always_comb begin
    cmp_en_s   = (state_r == ST_CHECK) && (chk_cnt_r != CNT_ZERO);
    cmp_addr_s = chk_cnt_r[ADDR_BITS-1:0] - ADDR_ONE;
    if (cmp_en_s) begin
      miscmp_s = (bus.mem_rdata != bist_pattern(pat_r, cmp_addr_s));
    end else begin
      miscmp_s = 1'b0;
    end
  end

  // State, bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r           <= ST_IDLE;
      addr_r            <= ADDR_ZERO;
      inc_r             <= 1'b0;
      pat_r             <= 2'b00;
      chk_cnt_r         <= CNT_ZERO;
      cmd_ready_r       <= 1'b0;
      rd_data_r         <= DATA_ZERO;
      rd_valid_r        <= 1'b0;
      bist_done_r       <= 1'b0;
      bist_fail_r       <= 1'b0;
      fail_cnt_r        <= 8'd0;
      first_fail_addr_r <= ADDR_ZERO;
      mem_addr_r        <= ADDR_ZERO;
      mem_wdata_r       <= DATA_ZERO;
      mem_we_r          <= 1'b0;
      mem_re_r          <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      addr_r      <= addr_nxt_s;
      inc_r       <= inc_nxt_s;
      pat_r       <= pat_nxt_s;
      chk_cnt_r   <= chk_cnt_nxt_s;
      cmd_ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_WDATA);
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_re_r    <= mem_re_nxt_s;
      rd_valid_r  <= (state_r == ST_RD_CAP);
      bist_done_r <= (state_r == ST_CHECK) && (chk_cnt_r == N_WORDS);
      if (state_r == ST_RD_CAP) begin
        rd_data_r <= bus.mem_rdata;
      end
      if (bist_start_s) begin
        bist_fail_r       <= 1'b0;
        fail_cnt_r        <= 8'd0;
        first_fail_addr_r <= ADDR_ZERO;
      end else if (miscmp_s) begin
        bist_fail_r <= 1'b1;
        if (fail_cnt_r != 8'hFF) begin
          fail_cnt_r <= fail_cnt_r + 8'd1;
        end
        if (fail_cnt_r == 8'd0) begin
          first_fail_addr_r <= cmp_addr_s;
        end
      end
    end
  end

  assign bus.cmd_ready       = cmd_ready_r;
  assign bus.rd_data         = rd_data_r;
  assign bus.rd_valid        = rd_valid_r;
  assign bus.bist_done       = bist_done_r;
  assign bus.bist_fail       = bist_fail_r;
  assign bus.fail_cnt        = fail_cnt_r;
  assign bus.first_fail_addr = first_fail_addr_r;
  assign bus.mem_addr        = mem_addr_r;
  assign bus.mem_wdata       = mem_wdata_r;
  assign bus.mem_we          = mem_we_r;
  assign bus.mem_re          = mem_re_r;
endmodule
